// File: rtl/cpu_pkg.sv
// Shared constants and fetch-state encoding for the 16-bit CPU front end.
package cpu_pkg;
    localparam int AW = 12;
    localparam int IW = 16;
    localparam logic [AW-1:0] RESET_PC_DEFAULT = 12'h000;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus decoder handshake and redirect.
interface instruction_fetch_unit_if;
    import cpu_pkg::*;

    logic          fetch_en;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic          jump_signal;
    logic [AW-1:0] jump_address;

    modport master (
        input  fetch_en, mem_rdata, mem_rvalid, inst_ready, jump_signal, jump_address,
        output mem_req, mem_addr, inst, inst_pc, inst_valid
    );

    modport slave (
        output fetch_en, mem_rdata, mem_rvalid, inst_ready, jump_signal, jump_address,
        input  mem_req, mem_addr, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// In-order 2-entry holding buffer: output register plus one prefetch register.
// Latency: a push into an empty (or draining) output register is visible next cycle.
// Backpressure: caller must not push when occ==2 and no pop; flush empties both entries.
module fetch_skid_buffer
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [IW-1:0] push_inst,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    output logic [IW-1:0] out_inst,
    output logic [AW-1:0] out_pc,
    output logic          out_vld,
    output logic [1:0]    occ
);
    logic [IW-1:0] out_inst_q, out_inst_d, buf_inst_q, buf_inst_d;
    logic [AW-1:0] out_pc_q, out_pc_d, buf_pc_q, buf_pc_d;
    logic          out_vld_q, out_vld_d, buf_vld_q, buf_vld_d;

    always_comb begin
        out_inst_d = out_inst_q;
        out_pc_d   = out_pc_q;
        out_vld_d  = out_vld_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        buf_vld_d  = buf_vld_q;
        if (flush) begin
            out_vld_d = 1'b0;
            buf_vld_d = 1'b0;
        end else if (!out_vld_q || pop) begin
            // Output slot frees up: the older prefetched word always goes first.
            if (buf_vld_q) begin
                out_inst_d = buf_inst_q;
                out_pc_d   = buf_pc_q;
                out_vld_d  = 1'b1;
                buf_vld_d  = push;
                if (push) begin
                    buf_inst_d = push_inst;
                    buf_pc_d   = push_pc;
                end
            end else begin
                out_vld_d = push;
                if (push) begin
                    out_inst_d = push_inst;
                    out_pc_d   = push_pc;
                end
            end
        end else if (push) begin
            buf_inst_d = push_inst;
            buf_pc_d   = push_pc;
            buf_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_inst_q <= '0;
            out_pc_q   <= '0;
            out_vld_q  <= 1'b0;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
            buf_vld_q  <= 1'b0;
        end else begin
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
            out_vld_q  <= out_vld_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            buf_vld_q  <= buf_vld_d;
        end
    end

    assign out_inst = out_inst_q;
    assign out_pc   = out_pc_q;
    assign out_vld  = out_vld_q;
    assign occ      = {1'b0, out_vld_q} + {1'b0, buf_vld_q};
endmodule

// File: rtl/instruction_fetch_unit.sv
// CPU front end: PC, single-outstanding instruction-memory requests, wrong-path DROP FSM.
// Latency: first inst_valid two cycles after reset release with a 1-cycle memory.
// Backpressure: stops requesting when two words are held; requests are never withdrawn.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [AW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    instruction_fetch_unit_if.master bus
);
    fetch_state_t  state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_req_q, mem_req_d;

    logic          consume, jump, complete, pending, push, issue;
    logic [AW-1:0] target;
    logic [IW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic [1:0]    occ, occ_next;

    assign consume  = inst_valid && bus.inst_ready;
    assign jump     = consume && bus.jump_signal;
    assign target   = inst_pc + bus.jump_address;
    assign complete = mem_req_q && bus.mem_rvalid;
    assign pending  = mem_req_q && !bus.mem_rvalid;
    // A word arriving alongside a taken jump is wrong-path and never stored.
    assign push     = (state_q == RUN) && complete && !jump;
    assign occ_next = jump ? 2'd0 : (occ - {1'b0, consume} + {1'b0, push});

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (jump) begin
            fetch_pc_d = target;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + AW'(1);
        end
        case (state_q)
            RUN:     if (jump && pending) state_d = DROP;
            DROP:    if (complete) state_d = RUN;
            default: state_d = RUN;
        endcase
        issue      = (state_q == RUN) && bus.fetch_en && !pending && (occ_next < 2'd2);
        mem_req_d  = pending || issue;
        mem_addr_d = issue ? fetch_pc_d : mem_addr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (jump),
        .push      (push),
        .push_inst (bus.mem_rdata),
        .push_pc   (mem_addr_q),
        .pop       (consume),
        .out_inst  (inst),
        .out_pc    (inst_pc),
        .out_vld   (inst_valid),
        .occ       (occ)
    );

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst       = inst;
    assign bus.inst_pc    = inst_pc;
    assign bus.inst_valid = inst_valid;
endmodule
